// File: rtl/pes_siso_shreg_if.sv
// Serial data link carrying one bit per clock into and out of the delay line.
// The producer side drives serial_in; the delay line returns serial_out.
interface pes_siso_shreg_if;
   logic serial_in;
   logic serial_out;

   modport master (
      output serial_in,
      input  serial_out
   );

   modport slave (
      input  serial_in,
      output serial_out
   );
endinterface

// File: rtl/pes_siso_shreg.sv
// Serial-in/serial-out shift register: delays a 1-bit stream by DEPTH clocks.
// Reset is synchronous and active-low; it clears every stage so in-flight bits are discarded.
module pes_siso_shreg #(
   parameter int DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   pes_siso_shreg_if.slave   sio
);

   logic [DEPTH-1:0] stage_q;
   logic [DEPTH-1:0] stage_d;

   // Element-wise next state avoids a negative part-select when DEPTH is 1.
   always_comb begin
      stage_d    = '0;
      stage_d[0] = sio.serial_in;
      for (int i = 1; i < DEPTH; i++) begin
         stage_d[i] = stage_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         stage_q <= '0;
      end else begin
         stage_q <= stage_d;
      end
   end

   // Output comes straight from the last flop, so there is no path from serial_in.
   assign sio.serial_out = stage_q[DEPTH-1];

endmodule

// File: tb/tb_pes_siso_shreg.sv
// Bench for pes_siso_shreg at DEPTH 1, 4 and 8 driven by one shared stream.
// Expected outputs come from a per-edge history of inputs and reset levels.
module tb_pes_siso_shreg;

   logic clk;
   logic reset;
   logic din;

   int   errors;
   int   checks;
   int   edge_cnt;

   bit   in_hist[$];
   bit   rst_hist[$];

   pes_siso_shreg_if sio1 ();
   pes_siso_shreg_if sio4 ();
   pes_siso_shreg_if sio8 ();

   assign sio1.serial_in = din;
   assign sio4.serial_in = din;
   assign sio8.serial_in = din;

   pes_siso_shreg #(.DEPTH(1)) u_d1 (.clk(clk), .reset(reset), .sio(sio1));
   pes_siso_shreg #(.DEPTH(4)) u_d4 (.clk(clk), .reset(reset), .sio(sio4));
   pes_siso_shreg #(.DEPTH(8)) u_d8 (.clk(clk), .reset(reset), .sio(sio8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Output after the last recorded edge e: the input sampled at edge e-d+1,
   // unless any edge in that window saw reset low, in which case 0.
   function automatic logic model_out(input int d);
      int e;
      int src;
      e   = in_hist.size() - 1;
      src = e - d + 1;
      for (int k = (src < 0 ? 0 : src); k <= e; k++) begin
         if (rst_hist[k] == 1'b0) return 1'b0;
      end
      if (src < 0) return 1'bx;
      return in_hist[src];
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s edge=%0d observed=%b expected=%b", tag, edge_cnt, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, "_d1"}, sio1.serial_out, model_out(1));
      check({tag, "_d4"}, sio4.serial_out, model_out(4));
      check({tag, "_d8"}, sio8.serial_out, model_out(8));
   endtask

   // One clock: drive inputs at negedge, confirm outputs did not follow the
   // input change, then take the edge, record it and check all three depths.
   task automatic step(input string tag, input logic r, input logic d);
      logic o1, o4, o8;
      @(negedge clk);
      o1    = sio1.serial_out;
      o4    = sio4.serial_out;
      o8    = sio8.serial_out;
      reset = r;
      din   = d;
      #1;
      if (in_hist.size() > 0) begin
         check({tag, "_hold_d1"}, sio1.serial_out, o1);
         check({tag, "_hold_d4"}, sio4.serial_out, o4);
         check({tag, "_hold_d8"}, sio8.serial_out, o8);
      end
      @(posedge clk);
      in_hist.push_back(d);
      rst_hist.push_back(r);
      #1;
      check_all(tag);
      $display("edge=%0d %s reset=%b in=%b out1=%b out4=%b out8=%b",
               edge_cnt, tag, r, d, sio1.serial_out, sio4.serial_out, sio8.serial_out);
      edge_cnt++;
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      edge_cnt = 0;
      reset    = 1'b1;
      din      = 1'b0;

      // Reset with serial_in=1: output must be 0, then stay 0 while flushing zeros.
      step("reset", 1'b0, 1'b1);
      check("reset_out_d4", sio4.serial_out, 1'b0);
      for (int i = 0; i < 3; i++) step("post_reset", 1'b1, 1'b0);
      check("post_reset_d4", sio4.serial_out, 1'b0);

      // Alternating stream, with an explicit reset first.
      step("reset", 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) step("alt", 1'b1, logic'(i % 2));

      // Single pulse, then enough zeros to flush DEPTH=8.
      for (int i = 0; i < 8; i++) step("zero", 1'b1, 1'b0);
      step("pulse", 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) step("pulse_tail", 1'b1, 1'b0);

      // All ones after reset.
      step("reset", 1'b0, 1'b0);
      for (int i = 0; i < 12; i++) step("ones", 1'b1, 1'b1);
      check("ones_steady_d8", sio8.serial_out, 1'b1);

      // Mid-stream reset while full of ones: the old ones must never appear.
      step("mid_reset", 1'b0, 1'b1);
      check("mid_reset_d4", sio4.serial_out, 1'b0);
      for (int i = 0; i < 10; i++) step("mid_flush", 1'b1, 1'b0);

      // Random stream with occasional resets.
      for (int i = 0; i < 80; i++) begin
         step("rand", ($urandom_range(0, 19) != 0), logic'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
